// File: rtl/alu_comparator_pipe.sv
// ---------------------------------------------------------------------------
// alu_comparator_pipe
//   Pipelined branch-condition / set-less-than / min-max evaluator.
//   Stage S0 registers the operands together with the three compare flags
//   (eq, signed lt, unsigned lt); later stages only carry them forward. The
//   last stage drives the out_* ports through a small select on the op code.
//   A valid/ready handshake with full back-pressure lets ops move one stage
//   per cycle, and empty stages (bubbles) fill even while the output stalls.
//
// Ports
//   soc_clk      clock, rising edge
//   reset        synchronous, active-high; clears every stage valid bit
//   in_valid     upstream has an op          in_ready    op accepted this cycle
//   in_op[3:0]   op code                     in_tag      opaque caller tag
//   in_a, in_b   WIDTH-bit operands
//   out_valid    result presented            out_ready   downstream consumes
//   out_con_met  condition result            out_result  data result
//   out_tag      tag of presented op         out_illegal op code unrecognised
//   busy         any stage holds a valid op
// ---------------------------------------------------------------------------
module alu_comparator_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
) (
  input  logic             soc_clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_con_met,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal,
  output logic             busy
);

  localparam int LAST = STAGES - 1;

  localparam logic [3:0] OP_BEQ  = 4'd0;
  localparam logic [3:0] OP_BNE  = 4'd1;
  localparam logic [3:0] OP_BLT  = 4'd2;
  localparam logic [3:0] OP_BGE  = 4'd3;
  localparam logic [3:0] OP_BLTU = 4'd4;
  localparam logic [3:0] OP_BGEU = 4'd5;
  localparam logic [3:0] OP_SLT  = 4'd9;
  localparam logic [3:0] OP_SLTU = 4'd10;
  localparam logic [3:0] OP_MIN  = 4'd11;
  localparam logic [3:0] OP_MAX  = 4'd12;
  localparam logic [3:0] OP_MINU = 4'd13;
  localparam logic [3:0] OP_MAXU = 4'd14;

  // Per-stage state. Only the valid bits are reset; payload is qualified by them.
  logic [STAGES-1:0] vld_q, vld_d;
  logic [STAGES-1:0] eq_q,  eq_d;
  logic [STAGES-1:0] lts_q, lts_d;
  logic [STAGES-1:0] ltu_q, ltu_d;
  logic [3:0]        op_q  [STAGES];
  logic [3:0]        op_d  [STAGES];
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  a_d   [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];
  logic [WIDTH-1:0]  b_d   [STAGES];
  logic [TAG_W-1:0]  tag_q [STAGES];
  logic [TAG_W-1:0]  tag_d [STAGES];

  // cap[k]: stage k may load this cycle (empty, or its content moves on).
  // cap[STAGES] stands for the downstream consumer.
  logic [STAGES:0] cap;
  logic            in_fire;

  function automatic logic [WIDTH-1:0] zext1(input logic bit_in);
    return {{(WIDTH-1){1'b0}}, bit_in};
  endfunction

  // Ready chain walks from the output back to S0; purely combinational, no skid.
  always_comb begin
    cap         = '0;
    cap[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      cap[k] = !vld_q[k] || cap[k+1];
    end
  end

  assign in_ready = !reset && cap[0];
  assign in_fire  = in_valid && in_ready;

  always_comb begin
    vld_d = vld_q;
    eq_d  = eq_q;
    lts_d = lts_q;
    ltu_d = ltu_q;
    op_d  = op_q;
    a_d   = a_q;
    b_d   = b_q;
    tag_d = tag_q;

    // S0: capture op and compute the compare flags once.
    if (cap[0]) begin
      vld_d[0] = in_fire;
      op_d[0]  = in_op;
      a_d[0]   = in_a;
      b_d[0]   = in_b;
      tag_d[0] = in_tag;
      eq_d[0]  = (in_a == in_b);
      lts_d[0] = ($signed(in_a) < $signed(in_b));
      ltu_d[0] = (in_a < in_b);
    end

    // S1..S(LAST): carry forward; an empty predecessor leaves a bubble.
    for (int k = 1; k < STAGES; k++) begin
      if (cap[k]) begin
        vld_d[k] = vld_q[k-1];
        op_d[k]  = op_q[k-1];
        a_d[k]   = a_q[k-1];
        b_d[k]   = b_q[k-1];
        tag_d[k] = tag_q[k-1];
        eq_d[k]  = eq_q[k-1];
        lts_d[k] = lts_q[k-1];
        ltu_d[k] = ltu_q[k-1];
      end
    end
  end

  always_ff @(posedge soc_clk) begin
    if (reset) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
    end
  end

  always_ff @(posedge soc_clk) begin
    eq_q  <= eq_d;
    lts_q <= lts_d;
    ltu_q <= ltu_d;
    op_q  <= op_d;
    a_q   <= a_d;
    b_q   <= b_d;
    tag_q <= tag_d;
  end

  // Output stage: result select, forced to zero whenever the last stage is empty.
  always_comb begin
    out_valid   = vld_q[LAST];
    busy        = |vld_q;
    out_con_met = 1'b0;
    out_result  = '0;
    out_tag     = '0;
    out_illegal = 1'b0;
    if (vld_q[LAST]) begin
      out_tag = tag_q[LAST];
      case (op_q[LAST])
        OP_BEQ:  out_con_met = eq_q[LAST];
        OP_BNE:  out_con_met = !eq_q[LAST];
        OP_BLT:  out_con_met = lts_q[LAST];
        OP_BGE:  out_con_met = !lts_q[LAST];
        OP_BLTU: out_con_met = ltu_q[LAST];
        OP_BGEU: out_con_met = !ltu_q[LAST];
        OP_SLT: begin
          out_con_met = lts_q[LAST];
          out_result  = zext1(lts_q[LAST]);
        end
        OP_SLTU: begin
          out_con_met = ltu_q[LAST];
          out_result  = zext1(ltu_q[LAST]);
        end
        OP_MIN: begin
          out_con_met = lts_q[LAST];
          out_result  = lts_q[LAST] ? a_q[LAST] : b_q[LAST];
        end
        OP_MAX: begin
          out_con_met = lts_q[LAST];
          out_result  = lts_q[LAST] ? b_q[LAST] : a_q[LAST];
        end
        OP_MINU: begin
          out_con_met = ltu_q[LAST];
          out_result  = ltu_q[LAST] ? a_q[LAST] : b_q[LAST];
        end
        OP_MAXU: begin
          out_con_met = ltu_q[LAST];
          out_result  = ltu_q[LAST] ? b_q[LAST] : a_q[LAST];
        end
        default: out_illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_comparator_pipe.sv
// ---------------------------------------------------------------------------
// tb_alu_comparator_pipe
//   Three instances: 32-bit/2-stage (directed table + hand sequences),
//   8-bit/1-stage and 8-bit/4-stage (latency + randomized scoreboard).
// ---------------------------------------------------------------------------
module tb_alu_comparator_pipe;

  logic soc_clk = 1'b0;
  always #5 soc_clk = ~soc_clk;

  logic reset;
  int   n_chk  = 0;
  int   n_fail = 0;

  // 32-bit, 2-stage instance
  logic        d0_in_valid, d0_in_ready, d0_out_valid, d0_out_ready;
  logic        d0_con, d0_ill, d0_busy;
  logic [3:0]  d0_op;
  logic [31:0] d0_a, d0_b, d0_res;
  logic [4:0]  d0_tin, d0_tout;

  // 8-bit instances: index 0 -> STAGES=1, index 1 -> STAGES=4
  logic       e_in_valid [2];
  logic       e_in_ready [2];
  logic       e_out_valid[2];
  logic       e_out_ready[2];
  logic       e_con      [2];
  logic       e_ill      [2];
  logic       e_busy     [2];
  logic [3:0] e_op       [2];
  logic [7:0] e_a        [2];
  logic [7:0] e_b        [2];
  logic [7:0] e_res      [2];
  logic [4:0] e_tin      [2];
  logic [4:0] e_tout     [2];

  alu_comparator_pipe #(.WIDTH(32), .STAGES(2), .TAG_W(5)) dut0 (
    .soc_clk(soc_clk), .reset(reset),
    .in_valid(d0_in_valid), .in_ready(d0_in_ready), .in_op(d0_op),
    .in_a(d0_a), .in_b(d0_b), .in_tag(d0_tin),
    .out_valid(d0_out_valid), .out_ready(d0_out_ready), .out_con_met(d0_con),
    .out_result(d0_res), .out_tag(d0_tout), .out_illegal(d0_ill), .busy(d0_busy)
  );

  alu_comparator_pipe #(.WIDTH(8), .STAGES(1), .TAG_W(5)) dut1 (
    .soc_clk(soc_clk), .reset(reset),
    .in_valid(e_in_valid[0]), .in_ready(e_in_ready[0]), .in_op(e_op[0]),
    .in_a(e_a[0]), .in_b(e_b[0]), .in_tag(e_tin[0]),
    .out_valid(e_out_valid[0]), .out_ready(e_out_ready[0]), .out_con_met(e_con[0]),
    .out_result(e_res[0]), .out_tag(e_tout[0]), .out_illegal(e_ill[0]), .busy(e_busy[0])
  );

  alu_comparator_pipe #(.WIDTH(8), .STAGES(4), .TAG_W(5)) dut2 (
    .soc_clk(soc_clk), .reset(reset),
    .in_valid(e_in_valid[1]), .in_ready(e_in_ready[1]), .in_op(e_op[1]),
    .in_a(e_a[1]), .in_b(e_b[1]), .in_tag(e_tin[1]),
    .out_valid(e_out_valid[1]), .out_ready(e_out_ready[1]), .out_con_met(e_con[1]),
    .out_result(e_res[1]), .out_tag(e_tout[1]), .out_illegal(e_ill[1]), .busy(e_busy[1])
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tag;
    logic        con;
    logic [31:0] res;
    logic        ill;
  } vec_t;

  vec_t tbl[16];
  vec_t st[6];

  // Scoreboards for the 8-bit instances: {con, res, tag, ill}
  logic [14:0] sb      [2][128];
  int          wr      [2];
  int          rd      [2];
  logic        stalled [2];
  logic [14:0] held_e  [2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge soc_clk);
    #1;
  endtask

  task automatic neg();
    @(negedge soc_clk);
  endtask

  // Reference: straight from the op definitions using wide integer arithmetic.
  function automatic void model(input int w, input logic [3:0] op, input logic [31:0] a,
                                input logic [31:0] b, output logic con,
                                output logic [31:0] res, output logic ill);
    longint m, ua, ub, sa, sbv;
    logic   lt_s, lt_u;
    m  = longint'(1) << w;
    ua = 0;
    ub = 0;
    ua[31:0] = a;
    ub[31:0] = b;
    ua = ua % m;
    ub = ub % m;
    sa  = (ua >= m / 2) ? ua - m : ua;
    sbv = (ub >= m / 2) ? ub - m : ub;
    lt_s = (sa < sbv);
    lt_u = (ua < ub);
    con = 1'b0;
    res = '0;
    ill = 1'b0;
    case (op)
      4'd0:  con = (ua == ub);
      4'd1:  con = (ua != ub);
      4'd2:  con = lt_s;
      4'd3:  con = (sa >= sbv);
      4'd4:  con = lt_u;
      4'd5:  con = (ua >= ub);
      4'd9:  begin con = lt_s; res = {31'd0, lt_s}; end
      4'd10: begin con = lt_u; res = {31'd0, lt_u}; end
      4'd11: begin con = lt_s; res = lt_s ? ua[31:0] : ub[31:0]; end
      4'd12: begin con = lt_s; res = lt_s ? ub[31:0] : ua[31:0]; end
      4'd13: begin con = lt_u; res = lt_u ? ua[31:0] : ub[31:0]; end
      4'd14: begin con = lt_u; res = lt_u ? ub[31:0] : ua[31:0]; end
      default: ill = 1'b1;
    endcase
  endfunction

  function automatic logic [63:0] d0_pack();
    return 64'({d0_con, d0_res, d0_tout, d0_ill});
  endfunction

  function automatic logic [63:0] vec_pack(input vec_t v);
    return 64'({v.con, v.res, v.tag, v.ill});
  endfunction

  function automatic logic [14:0] e_pack(input int j);
    return {e_con[j], e_res[j], e_tout[j], e_ill[j]};
  endfunction

  function automatic logic [7:0] pick8();
    case ($urandom_range(0, 5))
      0: return 8'h80;
      1: return 8'h7F;
      2: return 8'h00;
      3: return 8'hFF;
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic d0_drive(input vec_t v);
    d0_in_valid = 1'b1;
    d0_op  = v.op;
    d0_a   = v.a;
    d0_b   = v.b;
    d0_tin = v.tag;
  endtask

  // Called at the falling edge: retire/accept bookkeeping for both 8-bit instances.
  task automatic e_observe();
    logic        mc, mi;
    logic [31:0] mr;
    for (int j = 0; j < 2; j++) begin
      if (stalled[j]) check("rnd_hold", 64'(e_pack(j)), 64'(held_e[j]));
      if (e_out_valid[j] && e_out_ready[j]) begin
        if (rd[j] == wr[j]) begin
          check("rnd_extra_output", 64'(1), 64'(0));
        end else begin
          check("rnd_out", 64'(e_pack(j)), 64'(sb[j][rd[j] % 128]));
          rd[j]++;
        end
      end
      if (e_in_valid[j] && e_in_ready[j]) begin
        model(8, e_op[j], {24'd0, e_a[j]}, {24'd0, e_b[j]}, mc, mr, mi);
        sb[j][wr[j] % 128] = {mc, mr[7:0], e_tin[j], mi};
        wr[j]++;
      end
      stalled[j] = e_out_valid[j] && !e_out_ready[j];
      held_e[j]  = e_pack(j);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int          sent, got, lat;
    logic        found, mc, mi;
    logic [31:0] mr;
    logic [63:0] held;

    tbl[0]  = '{4'd2,  32'hFFFFFFFF, 32'h00000001, 5'd3,  1'b1, 32'h00000000, 1'b0};
    tbl[1]  = '{4'd4,  32'hFFFFFFFF, 32'h00000001, 5'd4,  1'b0, 32'h00000000, 1'b0};
    tbl[2]  = '{4'd9,  32'hFFFFFFFB, 32'h00000002, 5'd5,  1'b1, 32'h00000001, 1'b0};
    tbl[3]  = '{4'd14, 32'h80000000, 32'h7FFFFFFF, 5'd6,  1'b0, 32'h80000000, 1'b0};
    tbl[4]  = '{4'd7,  32'h00000009, 32'h00000009, 5'd7,  1'b0, 32'h00000000, 1'b1};
    tbl[5]  = '{4'd0,  32'h00000009, 32'h00000009, 5'd8,  1'b1, 32'h00000000, 1'b0};
    tbl[6]  = '{4'd11, 32'h00000005, 32'h00000005, 5'd9,  1'b0, 32'h00000005, 1'b0};
    tbl[7]  = '{4'd3,  32'h80000000, 32'h7FFFFFFF, 5'd10, 1'b0, 32'h00000000, 1'b0};
    tbl[8]  = '{4'd12, 32'h80000000, 32'h7FFFFFFF, 5'd11, 1'b1, 32'h7FFFFFFF, 1'b0};
    tbl[9]  = '{4'd13, 32'h80000000, 32'h7FFFFFFF, 5'd12, 1'b0, 32'h7FFFFFFF, 1'b0};
    tbl[10] = '{4'd1,  32'h00000001, 32'h00000002, 5'd13, 1'b1, 32'h00000000, 1'b0};
    tbl[11] = '{4'd5,  32'h00000001, 32'h00000002, 5'd14, 1'b0, 32'h00000000, 1'b0};
    tbl[12] = '{4'd10, 32'h00000001, 32'hFFFFFFFF, 5'd15, 1'b1, 32'h00000001, 1'b0};
    tbl[13] = '{4'd15, 32'h00000003, 32'h00000004, 5'd16, 1'b0, 32'h00000000, 1'b1};
    tbl[14] = '{4'd11, 32'hFFFFFFFE, 32'h00000003, 5'd17, 1'b1, 32'hFFFFFFFE, 1'b0};
    tbl[15] = '{4'd2,  32'h7FFFFFFF, 32'h80000000, 5'd18, 1'b0, 32'h00000000, 1'b0};

    reset = 1'b1;
    d0_in_valid = 1'b0; d0_out_ready = 1'b1; d0_op = '0; d0_a = '0; d0_b = '0; d0_tin = '0;
    for (int j = 0; j < 2; j++) begin
      e_in_valid[j] = 1'b0; e_out_ready[j] = 1'b1; e_op[j] = '0;
      e_a[j] = '0; e_b[j] = '0; e_tin[j] = '0;
      wr[j] = 0; rd[j] = 0; stalled[j] = 1'b0; held_e[j] = '0;
    end

    // ---- reset state ----
    repeat (2) tick();
    neg();
    check("rst_in_ready_low", 64'(d0_in_ready), 64'(0));
    check("rst_out_valid", 64'(d0_out_valid), 64'(0));
    check("rst_busy", 64'(d0_busy), 64'(0));
    check("rst_outputs_zero", d0_pack(), 64'(0));
    check("rst_e1_in_ready_low", 64'(e_in_ready[0]), 64'(0));
    check("rst_e4_busy", 64'(e_busy[1]), 64'(0));
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", 64'(d0_in_ready), 64'(1));
    tick();

    // ---- directed table, back-to-back, out_ready=1, latency 2 ----
    d0_out_ready = 1'b1;
    for (int i = 0; i < 18; i++) begin
      if (i < 16) d0_drive(tbl[i]);
      else d0_in_valid = 1'b0;
      neg();
      if (i < 16) check("tbl_in_ready", 64'(d0_in_ready), 64'(1));
      if (i >= 2) begin
        check("tbl_out_valid", 64'(d0_out_valid), 64'(1));
        check($sformatf("tbl_vec%0d", i - 2), d0_pack(), vec_pack(tbl[i-2]));
      end else begin
        check("tbl_latency_not_early", 64'(d0_out_valid), 64'(0));
      end
      tick();
    end
    neg();
    check("tbl_drained_valid", 64'(d0_out_valid), 64'(0));
    check("tbl_drained_busy", 64'(d0_busy), 64'(0));
    tick();

    // ---- 6 ops with out_ready held low for 5 cycles ----
    for (int k = 0; k < 6; k++) begin
      st[k].op  = 4'($urandom_range(0, 15));
      st[k].a   = $urandom;
      st[k].b   = (k == 2) ? st[k].a : $urandom;
      st[k].tag = 5'(20 + k);
      model(32, st[k].op, st[k].a, st[k].b, mc, mr, mi);
      st[k].con = mc; st[k].res = mr; st[k].ill = mi;
    end
    sent = 0; got = 0; held = '0;
    for (int c = 0; c < 30; c++) begin
      d0_out_ready = (c >= 5);
      if (sent < 6) d0_drive(st[sent]);
      else d0_in_valid = 1'b0;
      neg();
      if (c == 2) held = d0_pack();
      if (c >= 2 && c < 5) begin
        check("stall_in_ready_low", 64'(d0_in_ready), 64'(0));
        check("stall_out_valid", 64'(d0_out_valid), 64'(1));
        check("stall_hold", d0_pack(), held);
      end
      if (c == 5) begin
        check("full_pass_through_in_ready", 64'(d0_in_ready), 64'(1));
        check("full_pass_through_busy", 64'(d0_busy), 64'(1));
      end
      if (c == 6) check("occupancy_constant", 64'(d0_in_ready && d0_out_valid), 64'(1));
      if (d0_in_valid && d0_in_ready) sent++;
      if (d0_out_valid && d0_out_ready) begin
        if (got < 6) check($sformatf("stall_order%0d", got), d0_pack(), vec_pack(st[got]));
        else check("stall_duplicate", 64'(got), 64'(5));
        got++;
      end
      tick();
    end
    check("stall_retired_count", 64'(got), 64'(6));

    // ---- reset with two ops in flight ----
    d0_out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      d0_drive(tbl[c]);
      tick();
    end
    reset = 1'b1;
    d0_out_ready = 1'b1;
    d0_drive(tbl[5]);
    neg();
    check("midrst_in_ready_low", 64'(d0_in_ready), 64'(0));
    tick();
    reset = 1'b0;
    d0_in_valid = 1'b0;
    neg();
    check("midrst_out_valid", 64'(d0_out_valid), 64'(0));
    check("midrst_busy", 64'(d0_busy), 64'(0));
    check("midrst_outputs_zero", d0_pack(), 64'(0));
    for (int c = 0; c < 4; c++) begin
      tick();
      neg();
      check("midrst_no_stale", 64'(d0_out_valid), 64'(0));
    end
    tick();

    // ---- latency of the 8-bit instances ----
    for (int j = 0; j < 2; j++) begin
      e_out_ready[j] = 1'b1;
      e_in_valid[j] = 1'b1; e_op[j] = 4'd0; e_a[j] = 8'd1; e_b[j] = 8'd1; e_tin[j] = 5'd1;
      neg();
      check("lat_in_ready", 64'(e_in_ready[j]), 64'(1));
      tick();
      e_in_valid[j] = 1'b0;
      lat = 0; found = 1'b0;
      for (int c = 1; c <= 8 && !found; c++) begin
        neg();
        if (e_out_valid[j]) begin
          found = 1'b1;
          lat = c;
        end
        tick();
      end
      check($sformatf("latency_dut%0d", j + 1), 64'(lat), (j == 0) ? 64'(1) : 64'(4));
    end
    repeat (2) tick();

    // ---- randomized stream with random back-pressure ----
    for (int c = 0; c < 400; c++) begin
      for (int j = 0; j < 2; j++) begin
        e_in_valid[j]  = ($urandom_range(0, 3) != 0);
        e_op[j]        = 4'($urandom_range(0, 15));
        e_a[j]         = pick8();
        e_b[j]         = ($urandom_range(0, 4) == 0) ? e_a[j] : pick8();
        e_tin[j]       = 5'($urandom);
        e_out_ready[j] = ($urandom_range(0, 3) != 0);
      end
      neg();
      e_observe();
      tick();
    end
    for (int j = 0; j < 2; j++) begin
      e_in_valid[j] = 1'b0;
      e_out_ready[j] = 1'b1;
    end
    for (int c = 0; c < 10; c++) begin
      neg();
      e_observe();
      tick();
    end
    for (int j = 0; j < 2; j++) begin
      check($sformatf("rnd_all_retired_dut%0d", j + 1), 64'(rd[j]), 64'(wr[j]));
      check($sformatf("rnd_idle_dut%0d", j + 1), 64'(e_busy[j]), 64'(0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
